// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: assembles big-endian 32-bit words from a valid/ready byte link
// and writes them to the instruction memory at consecutive word addresses.
module instruction_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemData,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StWrite,
        StFinish,
        StFail,
        StDone
    } state_e;

    state_e      state_q;
    logic [15:0] count_q;
    logic [8:0]  word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] shift_q;

    logic        accept;
    logic [15:0] hdr_count;
    logic [8:0]  word_idx_nxt;

    always_comb begin
        accept       = RxValid && RxReady;
        hdr_count    = {count_q[15:8], RxData};
        word_idx_nxt = word_idx_q + 9'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            RxReady    <= 1'b0;
            MemWrite   <= 1'b0;
            MemAddress <= ADDR_BASE;
            MemData    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse raised only on entry to StWrite.
            MemWrite <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (Start) begin
                        state_q <= StHdrHi;
                        Busy    <= 1'b1;
                        Done    <= 1'b0;
                        Error   <= 1'b0;
                        RxReady <= 1'b1;
                    end
                end
                StHdrHi: begin
                    if (accept) begin
                        count_q[15:8] <= RxData;
                        state_q       <= StHdrLo;
                    end
                end
                StHdrLo: begin
                    if (accept) begin
                        count_q <= hdr_count;
                        if (hdr_count == 16'd0) begin
                            state_q <= StFinish;
                            RxReady <= 1'b0;
                        end else if ({16'd0, hdr_count} > DEPTH_WORDS) begin
                            state_q <= StFail;
                            RxReady <= 1'b0;
                        end else begin
                            state_q    <= StData;
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        shift_q    <= {shift_q[15:0], RxData};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q    <= StWrite;
                            RxReady    <= 1'b0;
                            MemWrite   <= 1'b1;
                            MemData    <= {shift_q, RxData};
                            MemAddress <= ADDR_BASE + {21'd0, word_idx_q, 2'b00};
                        end
                    end
                end
                StWrite: begin
                    word_idx_q <= word_idx_nxt;
                    if ({7'd0, word_idx_nxt} == count_q) begin
                        state_q <= StFinish;
                    end else begin
                        state_q <= StData;
                        RxReady <= 1'b1;
                    end
                end
                StFinish: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    state_q <= StDone;
                end
                StFail: begin
                    Busy    <= 1'b0;
                    Error   <= 1'b1;
                    state_q <= StDone;
                end
            endcase
        end
    end

endmodule
